otp_auth_ctrl: RTL and testbench

//  Parametrised OTP authentication controller, successor to the fixed 4-digit/3-try FSM.

---
 rtl/otp_auth_pkg.sv | 23 ++
 rtl/otp_digit_buffer.sv | 60 ++++++
 rtl/otp_auth_ctrl.sv | 130 +++++++++++++
 tb/tb_otp_auth_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_auth_pkg.sv
// Shared state encoding and default widths for the OTP authentication controller.
package otp_auth_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN      = 3'd1,
    ENTER    = 3'd2,
    CHECK    = 3'd3,
    UNLOCKED = 3'd4,
    EXPIRED  = 3'd5,
    LOCKED   = 3'd6
  } otp_state_t;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIGIT_W    = 4;
  localparam int CNT_W          = 4;

  // Minimum counter width able to hold 0..limit-1 without wrapping.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/otp_digit_buffer.sv
// Digit entry buffer: write/delete/clear one cycle after the strobe, never stalls.
// Delete support is compiled in only when OTP_DIGIT_DEL_EN is defined.
module otp_digit_buffer
  import otp_auth_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr,
  input  logic                          del,
  input  logic                          clr,
  input  logic [DIGIT_W-1:0]            din,
  output logic [NUM_DIGITS*DIGIT_W-1:0] buffer,
  output logic [CNT_W-1:0]              digit_cnt,
  output logic                          fill
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic do_wr;
  logic do_del;

`ifdef OTP_DIGIT_DEL_EN
  // A delete in the same cycle as a write wins and swallows the write.
  assign do_del = del && (digit_cnt != '0);
  assign do_wr  = wr && !del && (digit_cnt != FULL);
`else
  logic del_unused;
  assign del_unused = del;
  assign do_del     = 1'b0;
  assign do_wr      = wr && (digit_cnt != FULL);
`endif

  // High in the cycle whose write completes the entry.
  assign fill = do_wr && (digit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      buffer    <= '0;
      digit_cnt <= '0;
    end else if (do_del) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (CNT_W'(i) == digit_cnt - ONE)
          buffer[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] <= '0;
      end
      digit_cnt <= digit_cnt - ONE;
    end else if (do_wr) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (CNT_W'(i) == digit_cnt)
          buffer[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] <= din;
      end
      digit_cnt <= digit_cnt + ONE;
    end
  end

endmodule

// File: rtl/otp_auth_ctrl.sv
// OTP authentication FSM: final digit to unlock in 2 cycles; strobes outside ENTER are dropped.
// Digit delete is enabled by defining OTP_DIGIT_DEL_EN.
module otp_auth_ctrl
  import otp_auth_pkg::*;
#(
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter int DIGIT_W       = DEF_DIGIT_W,
  parameter int MAX_ATTEMPTS  = 3,
  parameter int EXPIRE_CYCLES = 1500000000,
  parameter int HOLD_CYCLES   = 250000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] lfsr_digit,
  input  logic                          lfsr_latch,
  input  logic [DIGIT_W-1:0]            user_digit,
  input  logic                          user_latch,
  input  logic                          user_del,
  output logic                          unlock,
  output logic                          expired,
  output logic                          reset_sys,
  output logic [3:0]                    wrng_atmpt,
  output logic [3:0]                    digit_cnt,
  output logic [NUM_DIGITS*DIGIT_W-1:0] user_otp_out,
  output logic [NUM_DIGITS*DIGIT_W-1:0] otp,
  output logic [2:0]                    state_out
);

  localparam int EW = cnt_width(EXPIRE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);

  otp_state_t     state, state_d;
  logic [EW-1:0]  exp_tmr;
  logic [HW-1:0]  hold_tmr;
  logic [3:0]     wrng_next;
  logic           buf_wr, buf_del, buf_clr, buf_fill;
  logic           timeout, match, terminal;

  assign timeout   = (exp_tmr == EW'(EXPIRE_CYCLES - 1));
  assign match     = (user_otp_out == otp);
  assign wrng_next = wrng_atmpt + 4'd1;
  assign terminal  = (state == UNLOCKED) || (state == EXPIRED) || (state == LOCKED);
  assign state_out = state;

  otp_digit_buffer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr        (buf_wr),
    .del       (buf_del),
    .clr       (buf_clr),
    .din       (user_digit),
    .buffer    (user_otp_out),
    .digit_cnt (digit_cnt),
    .fill      (buf_fill)
  );

  always_comb begin
    state_d = state;
    buf_wr  = 1'b0;
    buf_del = 1'b0;
    buf_clr = 1'b0;
    case (state)
      IDLE: begin
        buf_clr = 1'b1;
        state_d = GEN;
      end
      GEN: if (lfsr_latch) state_d = ENTER;
      ENTER: begin
        // Timeout beats a digit arriving in the same cycle.
        if (timeout) begin
          state_d = EXPIRED;
        end else begin
          buf_wr  = user_latch;
          buf_del = user_del;
          if (buf_fill) state_d = CHECK;
        end
      end
      CHECK: begin
        if (match) begin
          state_d = UNLOCKED;
        end else if (wrng_next == 4'(MAX_ATTEMPTS)) begin
          state_d = LOCKED;
        end else begin
          buf_clr = 1'b1;
          state_d = ENTER;
        end
      end
      UNLOCKED, EXPIRED, LOCKED: if (hold_tmr == HW'(HOLD_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      otp        <= '0;
      wrng_atmpt <= '0;
      exp_tmr    <= '0;
      hold_tmr   <= '0;
      unlock     <= 1'b0;
      expired    <= 1'b0;
      reset_sys  <= 1'b0;
    end else begin
      state     <= state_d;
      unlock    <= (state_d == UNLOCKED);
      expired   <= (state_d == EXPIRED);
      reset_sys <= (state_d == LOCKED);
      hold_tmr  <= (terminal && state_d == state) ? hold_tmr + HW'(1) : '0;
      case (state)
        IDLE: begin
          otp        <= '0;
          wrng_atmpt <= '0;
          exp_tmr    <= '0;
        end
        GEN: if (lfsr_latch) begin
          otp     <= lfsr_digit;
          exp_tmr <= '0;
        end
        // Session timer keeps running across retries; only IDLE/GEN restart it.
        ENTER: if (!timeout) exp_tmr <= exp_tmr + EW'(1);
        CHECK: if (!match) wrng_atmpt <= wrng_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Bench for otp_auth_ctrl with 4 digits, 3 attempts, 100-cycle expiry, 10-cycle hold.
module tb_otp_auth_ctrl;
  import otp_auth_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] lfsr_digit = '0;
  logic        lfsr_latch = 1'b0;
  logic [3:0]  user_digit = '0;
  logic        user_latch = 1'b0;
  logic        user_del = 1'b0;
  logic        unlock, expired, reset_sys;
  logic [3:0]  wrng_atmpt, digit_cnt;
  logic [15:0] user_otp_out, otp;
  logic [2:0]  state_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [2:0] st; logic [3:0] wrng; } exp_t;
  typedef struct {
    bit          new_sess;
    logic [15:0] otp_v;
    logic [15:0] entry;
    logic [2:0]  st;
    logic [3:0]  wrng;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  otp_auth_ctrl #(
    .NUM_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(3), .EXPIRE_CYCLES(100), .HOLD_CYCLES(10)
  ) dut (
    .clk(clk), .reset(reset), .lfsr_digit(lfsr_digit), .lfsr_latch(lfsr_latch),
    .user_digit(user_digit), .user_latch(user_latch), .user_del(user_del),
    .unlock(unlock), .expired(expired), .reset_sys(reset_sys), .wrng_atmpt(wrng_atmpt),
    .digit_cnt(digit_cnt), .user_otp_out(user_otp_out), .otp(otp), .state_out(state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Outcome scoreboard: pops whenever the FSM leaves CHECK or times out of ENTER.
  logic [2:0] prev_st = 3'd0;
  always @(negedge clk) begin
    exp_t e;
    if ((prev_st == CHECK && state_out != CHECK) || (prev_st == ENTER && state_out == EXPIRED)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: state 0x%0h, want no outcome pending", state_out);
      end else begin
        e = sb.pop_front();
        check("sb_state", {29'd0, state_out}, {29'd0, e.st});
        check("sb_wrng", {28'd0, wrng_atmpt}, {28'd0, e.wrng});
      end
    end
    prev_st = state_out;
  end

  function automatic logic sel(input int which);
    case (which)
      0:       return unlock;
      1:       return expired;
      default: return reset_sys;
    endcase
  endfunction

  task automatic wait_gen();
    for (int i = 0; i < 40 && state_out != GEN; i++) begin
      @(posedge clk); #1;
    end
    check("wait_gen", {29'd0, state_out}, {29'd0, GEN});
  endtask

  task automatic latch_otp(input logic [15:0] v);
    wait_gen();
    lfsr_digit = v; lfsr_latch = 1'b1;
    @(posedge clk); #1;
    lfsr_latch = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] d);
    user_digit = d; user_latch = 1'b1;
    @(posedge clk); #1;
    user_latch = 1'b0;
  endtask

  task automatic pulse_del();
    user_del = 1'b1;
    @(posedge clk); #1;
    user_del = 1'b0;
  endtask

  task automatic enter_entry(input logic [15:0] v);
    for (int i = 0; i < 4; i++) strobe(v[15-4*i -: 4]);
  endtask

  // Called with the selected output already observed high.
  task automatic run_hold(input int which, input string name);
    int n = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (sel(which)) n++;
      else break;
    end
    check({name, "_hold"}, n, 10);
    check({name, "_idle"}, {29'd0, state_out}, {29'd0, IDLE});
  endtask

  task automatic check_zero(input string p);
    check({p, "_state"}, {29'd0, state_out}, {29'd0, IDLE});
    check({p, "_unlock"}, {31'd0, unlock}, 0);
    check({p, "_expired"}, {31'd0, expired}, 0);
    check({p, "_reset_sys"}, {31'd0, reset_sys}, 0);
    check({p, "_wrng"}, {28'd0, wrng_atmpt}, 0);
    check({p, "_cnt"}, {28'd0, digit_cnt}, 0);
    check({p, "_user_otp"}, {16'd0, user_otp_out}, 0);
    check({p, "_otp"}, {16'd0, otp}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 16'h9999, ENTER,    4'd1};
    vecs[1] = '{1'b0, 16'h1234, 16'h9999, ENTER,    4'd2};
    vecs[2] = '{1'b0, 16'h1234, 16'h9999, LOCKED,   4'd3};
    vecs[3] = '{1'b1, 16'h5678, 16'h5679, ENTER,    4'd1};
    vecs[4] = '{1'b0, 16'h5678, 16'h5678, UNLOCKED, 4'd1};

    // Reset state
    @(posedge clk); #1;
    check_zero("rst");
    reset = 1'b0;

    // Correct entry, 2-cycle latency, 10-cycle unlock
    latch_otp(16'h1234);
    check("t1_otp", {16'd0, otp}, 32'h1234);
    check("t1_enter", {29'd0, state_out}, {29'd0, ENTER});
    sb.push_back('{UNLOCKED, 4'd0});
    strobe(4'd1);
    check("t1_cnt1", {28'd0, digit_cnt}, 1);
    check("t1_buf1", {16'd0, user_otp_out}, 32'h1000);
    strobe(4'd2); strobe(4'd3); strobe(4'd4);
    check("t1_check", {29'd0, state_out}, {29'd0, CHECK});
    check("t1_cnt4", {28'd0, digit_cnt}, 4);
    check("t1_buf4", {16'd0, user_otp_out}, 32'h1234);
    check("t1_unlock_early", {31'd0, unlock}, 0);
    @(posedge clk); #1;
    check("t1_unlock", {31'd0, unlock}, 1);
    run_hold(0, "t1");

    // Table: lockout session, then retry-then-success session
    foreach (vecs[i]) begin
      if (vecs[i].new_sess) latch_otp(vecs[i].otp_v);
      sb.push_back('{vecs[i].st, vecs[i].wrng});
      enter_entry(vecs[i].entry);
      @(posedge clk); #1;
      if (vecs[i].st == UNLOCKED) run_hold(0, "tbl_unlock");
      else if (vecs[i].st == LOCKED) run_hold(2, "tbl_locked");
      else check("tbl_cnt_clear", {28'd0, digit_cnt}, 0);
    end

    // Timeout 100 cycles after ENTER entry; digit on the final cycle dropped
    latch_otp(16'h4321);
    sb.push_back('{EXPIRED, 4'd0});
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      user_latch = 1'b0;
      if (k == 2 || k == 4) begin user_digit = 4'd4; user_latch = 1'b1; end
      if (k == 99) begin
        check("to_not_yet", {31'd0, expired}, 0);
        user_digit = 4'd5; user_latch = 1'b1;
      end
      if (k == 100) begin
        check("to_expired", {31'd0, expired}, 1);
        check("to_cnt", {28'd0, digit_cnt}, 2);
      end
    end
    run_hold(1, "to");

    // Delete
    latch_otp(16'h1234);
`ifdef OTP_DIGIT_DEL_EN
    sb.push_back('{UNLOCKED, 4'd0});
`else
    sb.push_back('{ENTER, 4'd1});
`endif
    strobe(4'd1); strobe(4'd2); strobe(4'd7);
    pulse_del();
`ifdef OTP_DIGIT_DEL_EN
    check("del_cnt", {28'd0, digit_cnt}, 2);
    check("del_buf", {16'd0, user_otp_out}, 32'h1200);
    strobe(4'd3); strobe(4'd4);
    @(posedge clk); #1;
    check("del_unlock", {31'd0, unlock}, 1);
    run_hold(0, "del");
`else
    check("del_cnt", {28'd0, digit_cnt}, 3);
    strobe(4'd3); strobe(4'd4);
    check("del_wrng", {28'd0, wrng_atmpt}, 1);
    check("del_cnt_clear", {28'd0, digit_cnt}, 0);
`endif
    do_reset();

    // Reset in ENTER after 2 digits
    latch_otp(16'h2468);
    strobe(4'd2); strobe(4'd4);
    check("rst2_cnt", {28'd0, digit_cnt}, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("rst2");
    reset = 1'b0;

    // user_latch in GEN ignored; simultaneous latch + delete
    wait_gen();
    strobe(4'd7);
    check("gen_ignore_cnt", {28'd0, digit_cnt}, 0);
    check("gen_ignore_state", {29'd0, state_out}, {29'd0, GEN});
    latch_otp(16'h1111);
    strobe(4'd1); strobe(4'd2);
    user_digit = 4'd9; user_latch = 1'b1; user_del = 1'b1;
    @(posedge clk); #1;
    user_latch = 1'b0; user_del = 1'b0;
`ifdef OTP_DIGIT_DEL_EN
    check("sim_cnt", {28'd0, digit_cnt}, 1);
    check("sim_buf", {16'd0, user_otp_out}, 32'h1000);
    pulse_del(); pulse_del();
    check("del_empty_cnt", {28'd0, digit_cnt}, 0);
    check("del_empty_buf", {16'd0, user_otp_out}, 0);
`else
    check("sim_cnt", {28'd0, digit_cnt}, 3);
    check("sim_buf", {16'd0, user_otp_out}, 32'h1290);
`endif
    do_reset();

    repeat (3) begin @(posedge clk); #1; end
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
